// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter and owner of the 64 x DATA_W memory bank (banks split on the address MSB).
// Build option DUAL_BANK_EN: per-bank round-robin with one accept per bank per cycle; otherwise one global pointer.
module mem_bank_arbiter #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic grant_a, grant_b;
  logic a_acc, b_acc;
  logic a_rvalid_reg, b_rvalid_reg;
  logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;

`ifdef DUAL_BANK_EN
  logic a_bank, b_bank, same_bank, pri_sel;
  logic pri_bank0_reg, pri_bank0_next;
  logic pri_bank1_reg, pri_bank1_next;

  assign a_bank    = a_addr[ADDR_W-1];
  assign b_bank    = b_addr[ADDR_W-1];
  assign same_bank = (a_bank == b_bank);
  // Only the pointer of the contested bank matters; different banks never conflict.
  assign pri_sel   = a_bank ? pri_bank1_reg : pri_bank0_reg;

  assign grant_a = a_valid && (!b_valid || !same_bank || !pri_sel);
  assign grant_b = b_valid && (!a_valid || !same_bank || pri_sel);

  always_comb begin
    pri_bank0_next = pri_bank0_reg;
    pri_bank1_next = pri_bank1_reg;
    if (a_acc && !a_bank) pri_bank0_next = 1'b1;
    if (a_acc &&  a_bank) pri_bank1_next = 1'b1;
    if (b_acc && !b_bank) pri_bank0_next = 1'b0;
    if (b_acc &&  b_bank) pri_bank1_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_bank0_reg <= 1'b0;
      pri_bank1_reg <= 1'b0;
    end else begin
      pri_bank0_reg <= pri_bank0_next;
      pri_bank1_reg <= pri_bank1_next;
    end
  end
`else
  logic pri_all_reg, pri_all_next;

  // One access per cycle overall: banks are ignored for arbitration.
  assign grant_a = a_valid && (!b_valid || !pri_all_reg);
  assign grant_b = b_valid && (!a_valid || pri_all_reg);

  always_comb begin
    pri_all_next = pri_all_reg;
    if (a_acc) pri_all_next = 1'b1;
    if (b_acc) pri_all_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pri_all_reg <= 1'b0;
    else     pri_all_reg <= pri_all_next;
  end
`endif

  assign a_ready = grant_a && !rst;
  assign b_ready = grant_b && !rst;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  // Two writes in one cycle always land in different banks, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (a_acc && a_we) mem[a_addr] <= a_wdata;
      if (b_acc && b_we) mem[b_addr] <= b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
      a_rdata_reg  <= '0;
      b_rdata_reg  <= '0;
    end else begin
      a_rvalid_reg <= a_acc && !a_we;
      b_rvalid_reg <= b_acc && !b_we;
      if (a_acc && !a_we) a_rdata_reg <= mem[a_addr];
      if (b_acc && !b_we) b_rdata_reg <= mem[b_addr];
    end
  end

  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter; expectations follow DUAL_BANK_EN when it is defined.
module tb_mem_bank_arbiter;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_ready, a_we, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_valid, b_ready, b_we, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;

  mem_bank_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; ready is sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    drive_a(1'b0, 6'd0, '0);
    @(negedge clk);
    check_eq("rst_a_ready", 32'(a_ready), 32'd0);
    step();
    check_eq("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("rst_a_rdata", 32'(a_rdata), 32'd0);
    check_eq("rst_b_rdata", 32'(b_rdata), 32'd0);
    idle();
    rst = 1'b0;

    // write then read addr 5
    drive_a(1'b1, 6'd5, 20'hABCDE);
    @(negedge clk);
    check_eq("wr5_a_ready", 32'(a_ready), 32'd1);
    step();
    drive_a(1'b0, 6'd5, '0);
    @(negedge clk);
    check_eq("rd5_a_ready", 32'(a_ready), 32'd1);
    check_eq("wr5_no_rvalid", 32'(a_rvalid), 32'd0);
    step();
    idle();
    check_eq("rd5_a_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("rd5_a_rdata", 32'(a_rdata), 32'hABCDE);
    step();
    check_eq("rd5_pulse_end", 32'(a_rvalid), 32'd0);
    check_eq("rd5_rdata_hold", 32'(a_rdata), 32'hABCDE);

    // reset clears memory and pointers (the write leaves bank-1 pointer favouring B)
    drive_a(1'b1, 6'd40, 20'hFFFFF);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_a(1'b0, 6'd41, '0);
    drive_b(1'b0, 6'd40, '0);
    @(negedge clk);
    check_eq("clr_a_ready", 32'(a_ready), 32'd1);
    check_eq("clr_b_wait", 32'(b_ready), 32'd0);
    step();
    a_valid = 1'b0;
    check_eq("clr_a_rvalid", 32'(a_rvalid), 32'd1);
    @(negedge clk);
    check_eq("clr_b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
    check_eq("clr_b_rvalid", 32'(b_rvalid), 32'd1);
    check_eq("clr_b_rdata40", 32'(b_rdata), 32'd0);

    // same-bank contention: A writes 3, B writes 7 (pointer ends at A), then both read
    drive_a(1'b1, 6'd3, 20'h00333);
    step();
    idle();
    drive_b(1'b1, 6'd7, 20'h00777);
    step();
    idle();
    drive_a(1'b0, 6'd3, '0);
    drive_b(1'b0, 6'd7, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("cont%0d_a_ready", i), 32'(a_ready), 32'((i % 2) == 0));
      check_eq($sformatf("cont%0d_b_ready", i), 32'(b_ready), 32'((i % 2) == 1));
      step();
      check_eq($sformatf("cont%0d_a_rvalid", i), 32'(a_rvalid), 32'((i % 2) == 0));
      check_eq($sformatf("cont%0d_b_rvalid", i), 32'(b_rvalid), 32'((i % 2) == 1));
      if ((i % 2) == 0) check_eq($sformatf("cont%0d_a_rdata", i), 32'(a_rdata), 32'h00333);
      else              check_eq($sformatf("cont%0d_b_rdata", i), 32'(b_rdata), 32'h00777);
    end
    idle();

    // cross-bank: A reads 2 (bank 0), B writes 34 (bank 1)
    drive_a(1'b0, 6'd2, '0);
    drive_b(1'b1, 6'd34, 20'h12345);
    @(negedge clk);
    check_eq("xb_a_ready", 32'(a_ready), 32'd1);
`ifdef DUAL_BANK_EN
    check_eq("xb_b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
    check_eq("xb_a_rvalid", 32'(a_rvalid), 32'd1);
`else
    check_eq("xb_b_wait", 32'(b_ready), 32'd0);
    step();
    a_valid = 1'b0;
    check_eq("xb_a_rvalid", 32'(a_rvalid), 32'd1);
    @(negedge clk);
    check_eq("xb_b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
`endif
    drive_a(1'b0, 6'd34, '0);
    step();
    idle();
    check_eq("xb_rd34_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("xb_rd34_rdata", 32'(a_rdata), 32'h12345);

    // reset mid-read
    drive_a(1'b1, 6'd1, 20'h11111);
    step();
    drive_a(1'b0, 6'd1, '0);
    step();
    idle();
    check_eq("mid_a_rvalid", 32'(a_rvalid), 32'd1);
    check_eq("mid_a_rdata", 32'(a_rdata), 32'h11111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("mid_rst_rdata", 32'(a_rdata), 32'd0);

    // streaming: fill 0..31, then read back one per cycle
    for (int k = 0; k < 32; k++) begin
      drive_a(1'b1, 6'(k), 20'h50000 + 20'(k * 3));
      step();
    end
    for (int k = 0; k < 32; k++) begin
      drive_a(1'b0, 6'(k), '0);
      @(negedge clk);
      check_eq($sformatf("strm%0d_ready", k), 32'(a_ready), 32'd1);
      step();
      check_eq($sformatf("strm%0d_rvalid", k), 32'(a_rvalid), 32'd1);
      check_eq($sformatf("strm%0d_rdata", k), 32'(a_rdata), 32'h50000 + 32'(k * 3));
    end
    idle();
    step();
    check_eq("strm_end_rvalid", 32'(a_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
